// File: rtl/vlsu_pkg.sv
// rtl/vlsu_pkg.sv - shared types and sizes for the VLSU sequential store aligner
package vlsu_pkg;

    localparam int unsigned NrExits   = 4;
    localparam int unsigned DLEN      = 64;
    localparam int unsigned BeatBytes = NrExits * DLEN / 8;
    localparam int unsigned OffBits   = $clog2(BeatBytes);
    localparam int unsigned LenBits   = 16;
    localparam int unsigned IdBits    = 4;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_e;

    typedef struct packed {
        logic [OffBits-1:0] off;
        logic [LenBits-1:0] nbytes;
        logic [IdBits-1:0]  id;
    } store_cmd_t;

endpackage

// File: rtl/vlsu_byte_rotator.sv
// rtl/vlsu_byte_rotator.sv - one-beat window select out of {hi, lo} by element offset
module vlsu_byte_rotator #(
    parameter int unsigned NumElems = 32,
    parameter int unsigned ElemW    = 8,
    parameter int unsigned OffW     = 5
) (
    input  logic [OffW-1:0]           off_i,
    input  logic [NumElems*ElemW-1:0] hi_i,
    input  logic [NumElems*ElemW-1:0] lo_i,
    output logic [NumElems*ElemW-1:0] out_o
);

    logic [2*NumElems*ElemW-1:0] window;

    assign window = {hi_i, lo_i};

    // Element j comes from hi[j-off] when j >= off, else from the top of lo (lo[N-off+j])
    always_comb begin
        out_o = '0;
        for (int j = 0; j < NumElems; j++) begin
            out_o[j*ElemW +: ElemW] = window[(NumElems - int'(off_i) + j)*ElemW +: ElemW];
        end
    end

endmodule

// File: rtl/vlsu_seq_store_align.sv
// rtl/vlsu_seq_store_align.sv - realigns deshuffled store beats to the bus offset and emits W beats
module vlsu_seq_store_align
    import vlsu_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [OffBits-1:0]     cmd_off_i,
    input  logic [LenBits-1:0]     cmd_nbytes_i,
    input  logic [IdBits-1:0]      cmd_id_i,
    input  logic                   seq_valid_i,
    output logic                   seq_ready_o,
    input  logic [BeatBytes*8-1:0] seq_nb_i,
    input  logic [BeatBytes*2-1:0] seq_en_i,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [BeatBytes*8-1:0] w_data_o,
    output logic [BeatBytes-1:0]   w_strb_o,
    output logic                   w_last_o,
    output logic                   done_valid_o,
    output logic [IdBits-1:0]      done_id_o
);

    state_e                 state_q, state_d;
    store_cmd_t             cmd_q;
    logic [LenBits-1:0]     rem_q;
    logic [BeatBytes*8-1:0] res_data_q;
    logic [BeatBytes-1:0]   res_strb_q;
    logic                   zero_done_q;

    logic                   cmd_hs;
    logic                   w_hs;
    logic [BeatBytes-1:0]   strb_in;
    logic                   last_in;
    logic                   fits;
    logic [LenBits:0]       off_plus_rem;
    logic [LenBits-1:0]     rem_step;
    logic [BeatBytes*8-1:0] rot_hi_data;
    logic [BeatBytes-1:0]   rot_hi_strb;
    logic [BeatBytes*8-1:0] rot_data;
    logic [BeatBytes-1:0]   rot_strb;

    assign cmd_hs = cmd_valid_i && cmd_ready_o;
    assign w_hs   = w_valid_o && w_ready_i;

    // The final input beat carries at most BeatBytes; it fits in one W beat unless the offset pushes it over
    assign last_in      = (rem_q <= LenBits'(BeatBytes));
    assign off_plus_rem = {{(LenBits + 1 - OffBits){1'b0}}, cmd_q.off} + {1'b0, rem_q};
    assign fits         = (off_plus_rem <= (LenBits + 1)'(BeatBytes));
    assign rem_step     = last_in ? rem_q : LenBits'(BeatBytes);

    // A byte is written when either of its nibbles is enabled and it lies inside the remaining length
    always_comb begin
        strb_in = '0;
        for (int b = 0; b < BeatBytes; b++) begin
            strb_in[b] = (seq_en_i[2*b] | seq_en_i[2*b+1]) && (LenBits'(b) < rem_q);
        end
    end

    // In FLUSH no new input exists, so the upper half of the window is zero and only residue survives
    assign rot_hi_data = (state_q == FLUSH) ? '0 : seq_nb_i;
    assign rot_hi_strb = (state_q == FLUSH) ? '0 : strb_in;

    vlsu_byte_rotator #(
        .NumElems (BeatBytes),
        .ElemW    (8),
        .OffW     (OffBits)
    ) u_rot_data (
        .off_i (cmd_q.off),
        .hi_i  (rot_hi_data),
        .lo_i  (res_data_q),
        .out_o (rot_data)
    );

    vlsu_byte_rotator #(
        .NumElems (BeatBytes),
        .ElemW    (1),
        .OffW     (OffBits)
    ) u_rot_strb (
        .off_i (cmd_q.off),
        .hi_i  (rot_hi_strb),
        .lo_i  (res_strb_q),
        .out_o (rot_strb)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: zero-length commands never leave IDLE; their completion comes from zero_done_q
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs && (cmd_nbytes_i != '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (w_hs && last_in) begin
                    state_d = fits ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (w_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: STREAM is a zero-cycle pass-through, FLUSH drives register-sourced residue
    always_comb begin
        cmd_ready_o  = 1'b0;
        seq_ready_o  = 1'b0;
        w_valid_o    = 1'b0;
        w_last_o     = 1'b0;
        w_data_o     = '0;
        w_strb_o     = '0;
        done_valid_o = zero_done_q;
        done_id_o    = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
            end
            STREAM: begin
                w_valid_o   = seq_valid_i;
                seq_ready_o = w_ready_i;
                w_last_o    = last_in && fits;
                w_data_o    = rot_data;
                w_strb_o    = rot_strb;
            end
            FLUSH: begin
                w_valid_o = 1'b1;
                w_last_o  = 1'b1;
                w_data_o  = rot_data;
                w_strb_o  = rot_strb;
            end
            DONE: begin
                done_valid_o = 1'b1;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
        if (done_valid_o) begin
            done_id_o = cmd_q.id;
        end
    end

    // Command latch, remaining length and residue of the previous input beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q       <= '0;
            rem_q       <= '0;
            res_data_q  <= '0;
            res_strb_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= cmd_hs && (cmd_nbytes_i == '0);
            if (cmd_hs) begin
                cmd_q.off    <= cmd_off_i;
                cmd_q.nbytes <= cmd_nbytes_i;
                cmd_q.id     <= cmd_id_i;
                rem_q        <= cmd_nbytes_i;
                res_data_q   <= '0;
                res_strb_q   <= '0;
            end else if ((state_q == STREAM) && w_hs) begin
                res_data_q <= seq_nb_i;
                res_strb_q <= strb_in;
                rem_q      <= rem_q - rem_step;
            end
        end
    end

    a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_valid_o && !w_ready_i) |=> (w_valid_o && $stable(w_data_o) && $stable(w_strb_o)));

    a_seq_only_stream: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (seq_valid_i && seq_ready_o) |-> (state_q == STREAM));

    a_last_final: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_valid_o && w_last_o) |-> ((state_q == FLUSH) || (rem_q <= LenBits'(BeatBytes))));

    a_rem_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == STREAM) |-> (rem_q <= cmd_q.nbytes));

endmodule
